sr_bank_arbiter: RTL and testbench

- Shared bank of WIDTH SR-type storage bits, each with sr_ff update semantics.
- NREQ requesters reach the bank through a round-robin arbiter.
- Each request names a bit address and an access mode: D, T, JK or raw SR. The block converts the request into S/R drive for the addressed bit.
- Sits between control logic issuing flip-flop style operations and the bank; the whole bank is visible on q.

---
 rtl/sr_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sr_bank_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin arbitrated bank of SR storage bits (optional SRB_LOCK_EN exclusive lock)
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    mode,
  input  logic [AW*NREQ-1:0]   addr,
  input  logic [NREQ-1:0]      din_a,
  input  logic [NREQ-1:0]      din_b,
`ifdef SRB_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     q,
  output logic                 err,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;

`ifdef SRB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sel;
  logic              found;
  logic [NREQ-1:0]   elig;
  logic [PW-1:0]     cur;
  logic              do_write;
  logic [1:0]        cur_mode;
  logic [AW-1:0]     cur_addr;
  logic              cur_a;
  logic              cur_b;
  logic              in_range;
  logic              qa;
  logic              s;
  logic              r;
  logic [WIDTH-1:0]  q_next;
  logic              wr_err;
`ifdef SRB_LOCK_EN
  logic [PW-1:0]     owner;
  logic              locked_hold;
`endif

  // Round-robin pick: first requester at or above the pointer that is not already granted
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Which requester drives the bank this edge: the lock owner while locked, else the arbiter pick
  always_comb begin
`ifdef SRB_LOCK_EN
    locked_hold = (state == LOCKED) && lock[owner];
    cur         = locked_hold ? owner : sel;
    do_write    = locked_hold ? req[owner] : found;
`else
    cur         = sel;
    do_write    = found;
`endif
    cur_mode = mode[2*cur +: 2];
    cur_addr = addr[AW*cur +: AW];
    cur_a    = din_a[cur];
    cur_b    = din_b[cur];
  end

  // Read the addressed bit and turn the flip-flop style operation into S/R drive
  always_comb begin
    in_range = (int'(cur_addr) < WIDTH);
    qa       = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (int'(cur_addr) == j) qa = q[j];
    end
    case (cur_mode)
      MODE_D:  begin s = cur_a;        r = ~cur_a;      end
      MODE_T:  begin s = cur_a & ~qa;  r = cur_a & qa;  end
      MODE_JK: begin s = cur_a & ~qa;  r = cur_b & qa;  end
      default: begin s = cur_a;        r = cur_b;       end
    endcase
  end

  // Next bank value: only the addressed bit may change; S=R=1 or a bad address flags an error
  always_comb begin
    q_next = q;
    wr_err = 1'b0;
    if (do_write) begin
      if (!in_range) begin
        wr_err = 1'b1;
      end else if (s && r) begin
        wr_err = 1'b1;
      end else begin
        for (int j = 0; j < WIDTH; j++) begin
          if (int'(cur_addr) == j) begin
            if (s)      q_next[j] = 1'b1;
            else if (r) q_next[j] = 1'b0;
          end
        end
      end
    end
  end

  // Arbitration state machine with registered grant, bank and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      q     <= '0;
      err   <= 1'b0;
`ifdef SRB_LOCK_EN
      owner <= '0;
`endif
    end else begin
      q   <= q_next;
      err <= err | wr_err;
`ifdef SRB_LOCK_EN
      if (locked_hold) begin
        state <= LOCKED;
      end else
`endif
      begin
        if (found) begin
          gnt <= NREQ'(1) << sel;
          ptr <= PW'((int'(sel) + 1) % NREQ);
`ifdef SRB_LOCK_EN
          owner <= sel;
          state <= lock[sel] ? LOCKED : GRANT;
`else
          state <= GRANT;
`endif
        end else begin
          gnt   <= '0;
          state <= IDLE;
        end
      end
    end
  end

  // A grant is outstanding in every state except IDLE
  always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - directed self-checking bench for sr_bank_arbiter
module tb_sr_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  mode;
  logic [15:0] addr;
  logic [3:0]  din_a;
  logic [3:0]  din_b;
`ifdef SRB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  sr_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .mode  (mode),
    .addr  (addr),
    .din_a (din_a),
    .din_b (din_b),
`ifdef SRB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .q     (q),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] m, input logic [3:0] ad,
                         input logic a, input logic b);
    mode[2*i +: 2] = m;
    addr[4*i +: 4] = ad;
    din_a[i]       = a;
    din_b[i]       = b;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    mode  = 8'h00;
    addr  = 16'h3210;
    din_a = 4'b1111;
    din_b = 4'b0000;
`ifdef SRB_LOCK_EN
    lock  = 4'b0000;
`endif
    tick();
    tick();
    checks++; if (q !== 8'h00)   begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
    checks++; if (gnt !== 4'h0)  begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b exp=%b", err, 1'b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
    req = 4'b0000;
    reset = 1'b1;
  endtask

  task automatic test_d_write();
    do_reset();
    set_req(0, 2'b00, 4'd3, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL d_gnt got=%b exp=%b", gnt, 4'b0001); end
    checks++; if (q !== 8'h08)     begin failures++; $display("FAIL d_q got=%h exp=%h", q, 8'h08); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL d_err got=%b exp=%b", err, 1'b0); end
    checks++; if (busy !== 1'b1)   begin failures++; $display("FAIL d_busy got=%b exp=%b", busy, 1'b1); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL d_idle_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL d_idle_busy got=%b exp=%b", busy, 1'b0); end
    // D with a=0 clears the bit
    din_a[0] = 1'b0;
    req = 4'b0001;
    tick();
    checks++; if (q !== 8'h00)     begin failures++; $display("FAIL d_clear_q got=%h exp=%h", q, 8'h00); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 4'(i), 1'b1, 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (gnt !== exp_gnt[n]) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt, exp_gnt[n]); end
      if (n == 3) begin
        checks++; if (q !== 8'h0F) begin failures++; $display("FAIL rr_q got=%h exp=%h", q, 8'h0F); end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_toggle();
    logic exp_q0 [3];
    exp_q0[0] = 1'b1; exp_q0[1] = 1'b0; exp_q0[2] = 1'b1;
    do_reset();
    set_req(1, 2'b01, 4'd0, 1'b1, 1'b0);
    req = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || q[0] !== exp_q0[n])
        begin failures++; $display("FAIL t_grant%0d got gnt=%b q0=%b exp gnt=0010 q0=%b", n, gnt, q[0], exp_q0[n]); end
      tick();
      checks++;
      if (gnt !== 4'b0000 || q[0] !== exp_q0[n])
        begin failures++; $display("FAIL t_mask%0d got gnt=%b q0=%b exp gnt=0000 q0=%b", n, gnt, q[0], exp_q0[n]); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_sr_illegal();
    do_reset();
    set_req(2, 2'b11, 4'd5, 1'b1, 1'b0);
    req = 4'b0100;
    tick();
    checks++; if (q !== 8'h20 || err !== 1'b0) begin failures++; $display("FAIL sr_set got q=%h err=%b exp q=20 err=0", q, err); end
    req = 4'b0000;
    tick();
    din_b[2] = 1'b1;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL sr_ill_gnt got=%b exp=%b", gnt, 4'b0100); end
    checks++; if (q !== 8'h20)     begin failures++; $display("FAIL sr_ill_q got=%h exp=%h", q, 8'h20); end
    checks++; if (err !== 1'b1)    begin failures++; $display("FAIL sr_ill_err got=%b exp=%b", err, 1'b1); end
    req = 4'b0000;
    tick();
    din_a[2] = 1'b0;
    req = 4'b0100;
    tick();
    checks++; if (q !== 8'h00 || err !== 1'b1) begin failures++; $display("FAIL sr_sticky got q=%h err=%b exp q=00 err=1", q, err); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_bad_addr();
    do_reset();
    set_req(3, 2'b00, 4'd1, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    checks++; if (q !== 8'h02 || err !== 1'b0) begin failures++; $display("FAIL ba_pre got q=%h err=%b exp q=02 err=0", q, err); end
    addr[15:12] = 4'd9;
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL ba_gnt got=%b exp=%b", gnt, 4'b1000); end
    checks++; if (q !== 8'h02)     begin failures++; $display("FAIL ba_q got=%h exp=%h", q, 8'h02); end
    checks++; if (err !== 1'b1)    begin failures++; $display("FAIL ba_err got=%b exp=%b", err, 1'b1); end
    req = 4'b0000;
    tick();
    addr[15:12] = 4'd2;
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000 || q !== 8'h06) begin failures++; $display("FAIL ba_write got gnt=%b q=%h exp gnt=1000 q=06", gnt, q); end
    reset = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || gnt !== 4'b0000 || err !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL ba_reset got q=%h gnt=%b err=%b busy=%b exp q=00 gnt=0000 err=0 busy=0", q, gnt, err, busy); end
    req = 4'b0000;
    reset = 1'b1;
    tick();
  endtask

`ifdef SRB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(0, 2'b10, 4'd0, 1'b1, 1'b0);
    set_req(1, 2'b00, 4'd1, 1'b1, 1'b0);
    lock = 4'b0001;
    req  = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_gnt%0d got=%b exp=%b", n, gnt, 4'b0001); end
    end
    checks++; if (q[0] !== 1'b1) begin failures++; $display("FAIL lock_q got=%b exp=%b", q[0], 1'b1); end
    lock = 4'b0000;
    req  = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL lock_release got=%b exp=%b", gnt, 4'b0010); end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_d_write();
    test_back_to_back();
    test_toggle();
    test_sr_illegal();
    test_bad_addr();
`ifdef SRB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
